// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: byte-addressed data memory with optional wait states, MEM/WB register
// and combinational branch resolution. Optional feature macro: MEM_MISALIGN_EXC_EN.
module mem_stage_ws #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned REG_AW      = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              EXMEM_valid_i,
  input  logic [31:0]       EXMEM_pc_branched_i,
  input  logic [31:0]       EXMEM_alu_i,
  input  logic              EXMEM_alu_do_branch_i,
  input  logic [31:0]       EXMEM_b_i,
  input  logic [REG_AW-1:0] EXMEM_reg_write_address_i,
  input  logic              EXMEM_ctrl_branch_i,
  input  logic [1:0]        EXMEM_ctrl_mem_read_i,
  input  logic              EXMEM_ctrl_mem_unsigned_i,
  input  logic [1:0]        EXMEM_ctrl_mem_write_i,
  input  logic              EXMEM_ctrl_reg_write_i,
  input  logic              EXMEM_ctrl_mem_to_reg_i,
  output logic [31:0]       MEMWB_mem_o,
  output logic [31:0]       MEMWB_alu_o,
  output logic [REG_AW-1:0] MEMWB_reg_write_address_o,
  output logic              MEMWB_ctrl_reg_write_o,
  output logic              MEMWB_ctrl_mem_to_reg_o,
  output logic [31:0]       MEM_pc_branched_o,
  output logic              MEM_do_branch_o,
  output logic              MEM_stall_o,
  output logic              MEM_misalign_o
);
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_q [DEPTH];

  logic             rd_legal, wr_legal, access, is_store, is_load;
  logic             go_c, suppress_c, stall_c, complete_c;
  logic [1:0]       size;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata, rword, ldata;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;

  assign MEM_pc_branched_o = EXMEM_pc_branched_i;
  assign MEM_do_branch_o   = EXMEM_valid_i & EXMEM_ctrl_branch_i & EXMEM_alu_do_branch_i;

  // Store wins when both a load and a store size are present.
  assign rd_legal = (EXMEM_ctrl_mem_read_i == SZ_BYTE) || (EXMEM_ctrl_mem_read_i == SZ_HALF) ||
                    (EXMEM_ctrl_mem_read_i == SZ_WORD);
  assign wr_legal = (EXMEM_ctrl_mem_write_i == SZ_BYTE) || (EXMEM_ctrl_mem_write_i == SZ_HALF) ||
                    (EXMEM_ctrl_mem_write_i == SZ_WORD);
  assign access   = EXMEM_valid_i & (rd_legal | wr_legal);
  assign is_store = EXMEM_valid_i & wr_legal;
  assign is_load  = access & ~is_store;
  assign size     = is_store ? EXMEM_ctrl_mem_write_i : EXMEM_ctrl_mem_read_i;
  assign idx      = EXMEM_alu_i[ADDR_W-1:2];

`ifdef MEM_MISALIGN_EXC_EN
  logic misalign_c;
  assign misalign_c = access & (((size == SZ_HALF) & EXMEM_alu_i[0]) |
                                ((size == SZ_WORD) & (EXMEM_alu_i[1:0] != 2'b00)));
  assign suppress_c = misalign_c;
  assign go_c       = access & ~misalign_c;
  assign lane       = EXMEM_alu_i[1:0];
`else
  assign suppress_c = 1'b0;
  assign go_c       = access;
  assign lane       = (size == SZ_WORD) ? 2'b00 :
                      (size == SZ_HALF) ? {EXMEM_alu_i[1], 1'b0} : EXMEM_alu_i[1:0];
`endif

  if (ADDR_W < 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^EXMEM_alu_i[31:ADDR_W];
  end

  // Lane enables and replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = EXMEM_b_i;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{EXMEM_b_i[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{EXMEM_b_i[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign rword = mem_q[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (size)
      SZ_BYTE: ldata = EXMEM_ctrl_mem_unsigned_i ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      SZ_HALF: ldata = EXMEM_ctrl_mem_unsigned_i ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: ldata = rword;
    endcase
  end

  // Memory array is intentionally not reset; a store lands only on its completing edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && complete_c && is_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (go_c && (WAIT_STATES != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_c) begin
          if (WAIT_STATES == 0) complete_c = 1'b1;
          else stall_c = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) stall_c = 1'b1;
        else complete_c = 1'b1;
      end
      default: stall_c = 1'b0;
    endcase
  end

  assign MEM_stall_o = stall_c;

  // MEM/WB: bubbles clear only the control bits, data fields hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      MEMWB_mem_o               <= '0;
      MEMWB_alu_o               <= '0;
      MEMWB_reg_write_address_o <= '0;
      MEMWB_ctrl_reg_write_o    <= 1'b0;
      MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
    end else if (stall_c || !EXMEM_valid_i || suppress_c) begin
      MEMWB_ctrl_reg_write_o    <= 1'b0;
      MEMWB_ctrl_mem_to_reg_o   <= 1'b0;
    end else begin
      MEMWB_mem_o               <= (complete_c && is_load) ? ldata : 32'h0;
      MEMWB_alu_o               <= EXMEM_alu_i;
      MEMWB_reg_write_address_o <= EXMEM_reg_write_address_i;
      MEMWB_ctrl_reg_write_o    <= EXMEM_ctrl_reg_write_i;
      MEMWB_ctrl_mem_to_reg_o   <= EXMEM_ctrl_mem_to_reg_i;
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) MEM_misalign_o <= 1'b0;
    else MEM_misalign_o <= suppress_c;
  end
`else
  assign MEM_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: two instances (0 and 3 wait states) against a byte-level memory model
// and a per-cycle expectation queue.
module tb_mem_stage_ws;
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        do_br;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        br;
    logic [1:0]  rsz;
    logic        uns;
    logic [1:0]  wsz;
    logic        rw;
    logic        m2r;
  } ins_t;

  typedef struct packed {
    logic [0:0]  d;
    logic        chk_comb;
    logic        stall;
    logic        do_br;
    logic [31:0] pc;
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mem_chk;
    logic [31:0] mem;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  ins_t        ins [2];
  logic [31:0] o_mem [2], o_alu [2], o_pc [2];
  logic [4:0]  o_rd [2];
  logic        o_rw [2], o_m2r [2], o_br [2], o_stall [2], o_mis [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_stage_ws #(.ADDR_W(10), .WAIT_STATES((g == 0) ? 0 : 3), .REG_AW(5)) dut (
      .clk_i                     (clk),
      .rst_i                     (rst[g]),
      .EXMEM_valid_i             (ins[g].valid),
      .EXMEM_pc_branched_i       (ins[g].pc),
      .EXMEM_alu_i               (ins[g].alu),
      .EXMEM_alu_do_branch_i     (ins[g].do_br),
      .EXMEM_b_i                 (ins[g].b),
      .EXMEM_reg_write_address_i (ins[g].rd),
      .EXMEM_ctrl_branch_i       (ins[g].br),
      .EXMEM_ctrl_mem_read_i     (ins[g].rsz),
      .EXMEM_ctrl_mem_unsigned_i (ins[g].uns),
      .EXMEM_ctrl_mem_write_i    (ins[g].wsz),
      .EXMEM_ctrl_reg_write_i    (ins[g].rw),
      .EXMEM_ctrl_mem_to_reg_i   (ins[g].m2r),
      .MEMWB_mem_o               (o_mem[g]),
      .MEMWB_alu_o               (o_alu[g]),
      .MEMWB_reg_write_address_o (o_rd[g]),
      .MEMWB_ctrl_reg_write_o    (o_rw[g]),
      .MEMWB_ctrl_mem_to_reg_o   (o_m2r[g]),
      .MEM_pc_branched_o         (o_pc[g]),
      .MEM_do_branch_o           (o_br[g]),
      .MEM_stall_o               (o_stall[g]),
      .MEM_misalign_o            (o_mis[g])
    );
  end

  // Reference state: byte memory with written-flags, and the held MEM/WB data fields.
  logic [7:0]  mm [2][1024];
  bit          kn [2][1024];
  logic [31:0] h_alu [2], h_mem [2];
  logic [4:0]  h_rd [2];
  bit          h_mk [2];
  exp_t        q[$];
  exp_t        prev, cur;
  bit          have_prev = 1'b0;
  int unsigned total = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit legal(input logic [1:0] s);
    return s != SZ_NONE;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] v, input int bits, input logic uns);
    if (bits == 8) return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (bits == 16) return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Comb outputs are checked in the cycle they belong to; registered ones one cycle later.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      if (have_prev) begin
        chk("memwb_reg_write", 32'(o_rw[prev.d]), 32'(prev.rw));
        chk("memwb_mem_to_reg", 32'(o_m2r[prev.d]), 32'(prev.m2r));
        chk("memwb_alu", o_alu[prev.d], prev.alu);
        chk("memwb_rd", 32'(o_rd[prev.d]), 32'(prev.rd));
        chk("misalign", 32'(o_mis[prev.d]), 32'(prev.mis));
        if (prev.mem_chk) chk("memwb_mem", o_mem[prev.d], prev.mem);
      end
      if (cur.chk_comb) begin
        chk("stall", 32'(o_stall[cur.d]), 32'(cur.stall));
        chk("do_branch", 32'(o_br[cur.d]), 32'(cur.do_br));
        chk("pc_branched", o_pc[cur.d], cur.pc);
      end
      prev = cur;
      have_prev = 1'b1;
    end
  end

  task automatic push_cycle(input int d, input ins_t in, input logic r, input exp_t e);
    @(posedge clk);
    #1;
    ins[d] = in;
    rst[d] = r;
    q.push_back(e);
  endtask

  task automatic do_reset(input int d, input int n);
    exp_t e;
    e = '0;
    e.d = 1'(d);
    e.mem_chk = 1'b1;
    h_alu[d] = '0; h_mem[d] = '0; h_rd[d] = '0; h_mk[d] = 1'b1;
    for (int i = 0; i < n; i++) push_cycle(d, ins_t'(0), 1'b1, e);
  endtask

  function automatic ins_t mk(input logic v, input logic [1:0] rsz, input logic [1:0] wsz,
                              input logic uns, input logic [31:0] alu, input logic [31:0] b);
    ins_t in;
    in = '0;
    in.valid = v;
    in.rsz = rsz;
    in.wsz = wsz;
    in.uns = uns;
    in.alu = alu;
    in.b = b;
    in.pc = $urandom;
    in.rd = 5'($urandom_range(1, 31));
    in.rw = (rsz != SZ_NONE) || (wsz == SZ_NONE);
    in.m2r = (rsz != SZ_NONE);
    return in;
  endfunction

  task automatic do_instr(input int d, input ins_t in);
    int ws, n, ai;
    bit rdl, wrl, acc, st, ld, mis, rk;
    logic [1:0] sz;
    logic [9:0] a;
    logic [31:0] res;
    exp_t e;
    ws = ws_of(d);
    rdl = legal(in.rsz);
    wrl = legal(in.wsz);
    acc = in.valid && (rdl || wrl);
    st = in.valid && wrl;
    ld = acc && !st;
    sz = st ? in.wsz : in.rsz;
    a = in.alu[9:0];
    mis = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    if (acc && (((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a[1:0] != 2'b00)))) begin
      mis = 1'b1; acc = 1'b0; st = 1'b0; ld = 1'b0;
    end
`else
    if (sz == SZ_HALF) a[0] = 1'b0;
    if (sz == SZ_WORD) a[1:0] = 2'b00;
`endif
    ai = int'(a);
    res = '0;
    rk = 1'b1;
    if (ld) begin
      case (sz)
        SZ_BYTE: begin
          res = ext({24'h0, mm[d][ai]}, 8, in.uns);
          rk = kn[d][ai];
        end
        SZ_HALF: begin
          res = ext({16'h0, mm[d][ai+1], mm[d][ai]}, 16, in.uns);
          rk = kn[d][ai] && kn[d][ai+1];
        end
        default: begin
          res = {mm[d][ai+3], mm[d][ai+2], mm[d][ai+1], mm[d][ai]};
          rk = kn[d][ai] && kn[d][ai+1] && kn[d][ai+2] && kn[d][ai+3];
        end
      endcase
    end
    n = acc ? ws + 1 : 1;
    for (int c = 0; c < n; c++) begin
      e = '0;
      e.d = 1'(d);
      e.chk_comb = 1'b1;
      e.stall = (c < n - 1);
      e.do_br = in.valid & in.br & in.do_br;
      e.pc = in.pc;
      if ((c == n - 1) && in.valid && !mis) begin
        h_alu[d] = in.alu; h_rd[d] = in.rd; h_mem[d] = res; h_mk[d] = rk;
        e.rw = in.rw;
        e.m2r = in.m2r;
      end
      e.mis = mis;
      e.alu = h_alu[d];
      e.rd = h_rd[d];
      e.mem = h_mem[d];
      e.mem_chk = h_mk[d];
      push_cycle(d, in, 1'b0, e);
    end
    if (st) begin
      for (int k = 0; k < ((sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4); k++) begin
        mm[d][ai+k] = in.b[8*k +: 8];
        kn[d][ai+k] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int d);
    do_instr(d, mk(1'b0, SZ_NONE, SZ_NONE, 1'b0, $urandom, $urandom));
  endtask

  // Load followed by an idle cycle; the held MEM/WB data is pinned to a literal.
  task automatic load_lit(input int d, input string name, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] expv);
    do_instr(d, mk(1'b1, sz, SZ_NONE, uns, addr, $urandom));
    idle(d);
    @(negedge clk);
    chk(name, o_mem[d], expv);
  endtask

  // Store aborted by reset on its second wait cycle.
  task automatic sw_abort(input int d);
    ins_t in;
    exp_t e;
    in = mk(1'b1, SZ_NONE, SZ_WORD, 1'b0, 32'h0000_0020, 32'h1234_5678);
    for (int c = 0; c < 2; c++) begin
      e = '0;
      e.d = 1'(d); e.chk_comb = 1'b1; e.stall = 1'b1; e.pc = in.pc;
      e.alu = h_alu[d]; e.rd = h_rd[d]; e.mem = h_mem[d]; e.mem_chk = h_mk[d];
      push_cycle(d, in, 1'b0, e);
    end
    e = '0;
    e.d = 1'(d); e.mem_chk = 1'b1;
    h_alu[d] = '0; h_mem[d] = '0; h_rd[d] = '0; h_mk[d] = 1'b1;
    push_cycle(d, in, 1'b1, e);
    idle(d);
    @(negedge clk);
    chk("abort_stall_low", 32'(o_stall[d]), 32'h0);
    chk("abort_memwb_zero", o_alu[d], 32'h0);
  endtask

  task automatic run_suite(input int d);
    ins_t in;
    do_reset(d, 2);
    idle(d);
    @(negedge clk);
    chk("reset_reg_write", 32'(o_rw[d]), 32'h0);
    chk("reset_mem", o_mem[d], 32'h0);
    do_instr(d, mk(1'b1, SZ_NONE, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF));
    load_lit(d, "lw_deadbeef", SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    do_instr(d, mk(1'b1, SZ_NONE, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h1234_5680));
    load_lit(d, "lb_sext", SZ_BYTE, 1'b0, 32'h0000_0013, 32'hFFFF_FF80);
    load_lit(d, "lbu_zext", SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0000_0080);
    load_lit(d, "lw_after_sb", SZ_WORD, 1'b0, 32'h0000_0010, 32'h80AD_BEEF);
    do_instr(d, mk(1'b1, SZ_NONE, SZ_WORD, 1'b0, 32'hFFFF_FC20, 32'hCAFE_F00D));
    load_lit(d, "lhu_hi", SZ_HALF, 1'b1, 32'h0000_0022, 32'h0000_CAFE);
`ifndef MEM_MISALIGN_EXC_EN
    load_lit(d, "lh_misaligned", SZ_HALF, 1'b0, 32'h0000_0021, 32'hFFFF_F00D);
    load_lit(d, "lw_misaligned", SZ_WORD, 1'b0, 32'h0000_0013, 32'h80AD_BEEF);
`endif
    do_instr(d, mk(1'b1, SZ_WORD, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h0000_0077));
    idle(d);
    @(negedge clk);
    chk("store_priority_mem", o_mem[d], 32'h0);
    load_lit(d, "lw_store_prio", SZ_WORD, 1'b0, 32'h0000_0010, 32'h80AD_77EF);
    in = mk(1'b1, SZ_NONE, SZ_NONE, 1'b0, 32'h5, 32'h0);
    in.br = 1'b1; in.do_br = 1'b1; in.pc = 32'h0000_0400;
    do_instr(d, in);
    @(negedge clk);
    chk("branch_taken", 32'(o_br[d]), 32'h1);
    chk("branch_target", o_pc[d], 32'h0000_0400);
    in.valid = 1'b0;
    do_instr(d, in);
    @(negedge clk);
    chk("branch_invalid", 32'(o_br[d]), 32'h0);
    if (ws_of(d) != 0) begin
      sw_abort(d);
      load_lit(d, "lw_after_abort", SZ_WORD, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
    end
    for (int i = 0; i < 64; i++)
      do_instr(d, mk(1'b1, SZ_NONE, SZ_WORD, 1'b0, ($urandom & 32'hFFFF_FC00) | 32'(4 * i), $urandom));
    for (int i = 0; i < 250; i++) begin
      in = mk(($urandom_range(0, 99) < 85), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : SZ_NONE,
              1'($urandom_range(0, 1)),
              ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255)), $urandom);
      in.br = 1'($urandom_range(0, 1));
      in.do_br = 1'($urandom_range(0, 1));
      in.rw = 1'($urandom_range(0, 1));
      in.m2r = 1'($urandom_range(0, 1));
      do_instr(d, in);
    end
    idle(d);
    idle(d);
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    ins[0] = '0;
    ins[1] = '0;
    for (int d = 0; d < 2; d++) begin
      h_alu[d] = '0; h_mem[d] = '0; h_rd[d] = '0; h_mk[d] = 1'b1;
      for (int i = 0; i < 1024; i++) begin
        mm[d][i] = 8'h00;
        kn[d][i] = 1'b0;
      end
    end
    run_suite(0);
    run_suite(1);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
